// File: rtl/serial_word_assembler.sv
// Assembles strobed serial bits MSB-first into WIDTH-bit words with optional even parity
// and an inter-bit timeout, then buffers accepted words in a show-ahead FIFO.
module serial_word_assembler #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int PARITY  = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bitIn,
  input  logic                     bitValid,
  output logic [WIDTH-1:0]         wordOut,
  output logic                     wordValid,
  input  logic                     wordReady,
  output logic [$clog2(DEPTH):0]   fifoCount,
  output logic                     busy,
  output logic                     parityErr,
  output logic                     timeoutErr,
  output logic                     overflowErr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BC_W  = $clog2(WIDTH + 1);
  localparam int ID_W  = $clog2(TIMEOUT);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [ID_W-1:0]  IDLE_MAX = ID_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COLLECT    = 2'd1,
    PARITY_CHK = 2'd2
  } state_e;

  // Returns 1 when data plus parity bit has odd weight (even-parity failure).
  function automatic logic parity_bad_f(input logic [WIDTH-1:0] data, input logic par);
    return (^data) ^ par;
  endfunction

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ID_W-1:0]   idle_q, idle_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              par_err_q, to_err_q, ovf_err_q;

  logic              complete_s, par_fail_s, timeout_s;
  logic [WIDTH-1:0]  word_s;
  logic              push_s, pop_s, full_s, overflow_s;

  // State register and all control/FIFO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      idle_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      par_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      idle_q    <= idle_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      par_err_q <= par_fail_s;
      to_err_q  <= timeout_s;
      ovf_err_q <= overflow_s;
    end
  end

  // FIFO storage; contents are never visible while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_q] <= word_s;
    end
  end

  // Next-state logic: bit collection, parity check and inter-bit timeout.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    idle_d     = idle_q;
    complete_s = 1'b0;
    par_fail_s = 1'b0;
    timeout_s  = 1'b0;
    word_s     = {shift_q[WIDTH-2:0], bitIn};
    case (state_q)
      IDLE: begin
        idle_d = '0;
        if (bitValid) begin
          shift_d   = {{(WIDTH-1){1'b0}}, bitIn};
          bit_cnt_d = BC_W'(1);
          state_d   = COLLECT;
        end else begin
          bit_cnt_d = '0;
        end
      end
      COLLECT: begin
        if (bitValid) begin
          idle_d  = '0;
          shift_d = {shift_q[WIDTH-2:0], bitIn};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (PARITY != 0) begin
              state_d = PARITY_CHK;
            end else begin
              complete_s = 1'b1;
              state_d    = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end else if (idle_q == IDLE_MAX) begin
          timeout_s = 1'b1;
          shift_d   = '0;
          bit_cnt_d = '0;
          idle_d    = '0;
          state_d   = IDLE;
        end else begin
          idle_d = idle_q + ID_W'(1);
        end
      end
      PARITY_CHK: begin
        word_s = shift_q;
        if (bitValid) begin
          idle_d  = '0;
          state_d = IDLE;
          if (parity_bad_f(shift_q, bitIn)) begin
            par_fail_s = 1'b1;
          end else begin
            complete_s = 1'b1;
          end
        end else if (idle_q == IDLE_MAX) begin
          timeout_s = 1'b1;
          shift_d   = '0;
          bit_cnt_d = '0;
          idle_d    = '0;
          state_d   = IDLE;
        end else begin
          idle_d = idle_q + ID_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        shift_d   = '0;
        bit_cnt_d = '0;
        idle_d    = '0;
      end
    endcase
  end

  // FIFO control: a full FIFO still accepts a push when the head pops on the same edge.
  always_comb begin
    pop_s      = (count_q != '0) && wordReady;
    full_s     = (count_q == FULL_CNT);
    push_s     = complete_s && (!full_s || pop_s);
    overflow_s = complete_s && full_s && !pop_s;
    wr_d       = push_s ? wr_q + PTR_W'(1) : wr_q;
    rd_d       = pop_s  ? rd_q + PTR_W'(1) : rd_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign wordValid   = (count_q != '0);
  assign wordOut     = wordValid ? mem_q[rd_q] : '0;
  assign fifoCount   = count_q;
  assign busy        = (state_q != IDLE);
  assign parityErr   = par_err_q;
  assign timeoutErr  = to_err_q;
  assign overflowErr = ovf_err_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed self-checking bench for serial_word_assembler (WIDTH=8, DEPTH=4, PARITY=1, TIMEOUT=64).
module tb_serial_word_assembler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bitIn = 1'b0;
  logic       bitValid = 1'b0;
  logic       wordReady = 1'b0;
  logic [7:0] wordOut;
  logic       wordValid;
  logic [2:0] fifoCount;
  logic       busy, parityErr, timeoutErr, overflowErr;
  int         vectors = 0;
  int         miscompares = 0;

  serial_word_assembler dut (
    .clk(clk), .rst(rst), .bitIn(bitIn), .bitValid(bitValid),
    .wordOut(wordOut), .wordValid(wordValid), .wordReady(wordReady),
    .fifoCount(fifoCount), .busy(busy), .parityErr(parityErr),
    .timeoutErr(timeoutErr), .overflowErr(overflowErr)
  );

  always #5 clk = ~clk;

  // One strobed bit per cycle; returns 1 time unit after the accepting edge.
  task automatic send_bit(input logic b);
    bitIn = b; bitValid = 1'b1;
    @(posedge clk); #1;
    bitValid = 1'b0; bitIn = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par);
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    send_bit(par);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bitValid = 1'b1; bitIn = 1'b1; wordReady = 1'b1;
    idle(2);
    bitValid = 1'b0; bitIn = 1'b0; wordReady = 1'b0;
    vectors++;
    if ({wordOut, wordValid, fifoCount, busy, parityErr, timeoutErr, overflowErr} !== 15'd0) begin
      $display("FAIL reset_outputs: got %h wv=%b cnt=%0d busy=%b errs=%b%b%b, want all 0",
               wordOut, wordValid, fifoCount, busy, parityErr, timeoutErr, overflowErr);
      miscompares++;
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    send_bit(1'b1);
    vectors++;
    if (busy !== 1'b1) begin $display("FAIL busy_rise: got %b want 1", busy); miscompares++; end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0);
    vectors++;
    if (wordOut !== 8'hB2 || wordValid !== 1'b1 || fifoCount !== 3'd1) begin
      $display("FAIL basic_word: got %h wv=%b cnt=%0d want b2 1 1", wordOut, wordValid, fifoCount);
      miscompares++;
    end
    vectors++;
    if ({busy, parityErr, timeoutErr, overflowErr} !== 4'b0000) begin
      $display("FAIL basic_flags: got %b want 0000", {busy, parityErr, timeoutErr, overflowErr});
      miscompares++;
    end
    wordReady = 1'b1; idle(1); wordReady = 1'b0;
    vectors++;
    if (fifoCount !== 3'd0 || wordOut !== 8'h00 || wordValid !== 1'b0) begin
      $display("FAIL basic_pop: got cnt=%0d word=%h wv=%b want 0 00 0", fifoCount, wordOut, wordValid);
      miscompares++;
    end
  endtask

  task automatic test_bad_parity();
    send_frame(8'hB2, 1'b1);
    vectors++;
    if (parityErr !== 1'b1 || fifoCount !== 3'd0 || busy !== 1'b0) begin
      $display("FAIL bad_parity: got perr=%b cnt=%0d busy=%b want 1 0 0", parityErr, fifoCount, busy);
      miscompares++;
    end
    idle(1);
    vectors++;
    if (parityErr !== 1'b0) begin $display("FAIL parity_pulse_len: got %b want 0", parityErr); miscompares++; end
  endtask

  task automatic test_timeout();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    idle(62);
    vectors++;
    if (timeoutErr !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL timeout_early: got terr=%b busy=%b want 0 1", timeoutErr, busy);
      miscompares++;
    end
    idle(1);
    vectors++;
    if (timeoutErr !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL timeout_fire: got terr=%b busy=%b want 1 0", timeoutErr, busy);
      miscompares++;
    end
    idle(1);
    vectors++;
    if (timeoutErr !== 1'b0) begin $display("FAIL timeout_pulse_len: got %b want 0", timeoutErr); miscompares++; end
    send_frame(8'h5A, 1'b0);
    vectors++;
    if (wordOut !== 8'h5A || fifoCount !== 3'd1) begin
      $display("FAIL timeout_recover: got %h cnt=%0d want 5a 1", wordOut, fifoCount);
      miscompares++;
    end
    wordReady = 1'b1; idle(1); wordReady = 1'b0;
    // A bit arriving exactly on the expiry cycle keeps the frame alive.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    idle(62);
    send_bit(1'b1);
    vectors++;
    if (timeoutErr !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL bit_wins_expiry: got terr=%b busy=%b want 0 1", timeoutErr, busy);
      miscompares++;
    end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    vectors++;
    if (wordOut !== 8'h5A || fifoCount !== 3'd1 || timeoutErr !== 1'b0) begin
      $display("FAIL late_bit_frame: got %h cnt=%0d terr=%b want 5a 1 0", wordOut, fifoCount, timeoutErr);
      miscompares++;
    end
    wordReady = 1'b1; idle(1); wordReady = 1'b0;
  endtask

  task automatic fill_four();
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b0);
    send_frame(8'h04, 1'b1);
  endtask

  task automatic drain_check(input logic [7:0] first, input string tag);
    logic [7:0] exp;
    exp = first;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wordOut !== exp) begin
        $display("FAIL %s_drain%0d: got %h want %h", tag, i, wordOut, exp);
        miscompares++;
      end
      wordReady = 1'b1; idle(1); wordReady = 1'b0;
      exp = exp + 8'd1;
    end
    vectors++;
    if (fifoCount !== 3'd0 || wordValid !== 1'b0) begin
      $display("FAIL %s_empty: got cnt=%0d wv=%b want 0 0", tag, fifoCount, wordValid);
      miscompares++;
    end
  endtask

  task automatic test_overflow();
    fill_four();
    vectors++;
    if (fifoCount !== 3'd4) begin $display("FAIL ovf_fill: got %0d want 4", fifoCount); miscompares++; end
    send_frame(8'h05, 1'b0);
    vectors++;
    if (overflowErr !== 1'b1 || fifoCount !== 3'd4 || parityErr !== 1'b0) begin
      $display("FAIL ovf_pulse: got oerr=%b cnt=%0d perr=%b want 1 4 0", overflowErr, fifoCount, parityErr);
      miscompares++;
    end
    idle(1);
    vectors++;
    if (overflowErr !== 1'b0) begin $display("FAIL ovf_pulse_len: got %b want 0", overflowErr); miscompares++; end
    drain_check(8'h01, "ovf");
  endtask

  task automatic test_full_pop();
    fill_four();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 || i == 2);
    wordReady = 1'b1;
    send_bit(1'b0);
    wordReady = 1'b0;
    vectors++;
    if (overflowErr !== 1'b0 || fifoCount !== 3'd4) begin
      $display("FAIL full_pop: got oerr=%b cnt=%0d want 0 4", overflowErr, fifoCount);
      miscompares++;
    end
    drain_check(8'h02, "fullpop");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h03, 1'b0);
    send_frame(8'h04, 1'b1);
    vectors++;
    if (fifoCount !== 3'd2 || wordOut !== 8'h03) begin
      $display("FAIL b2b_push: got cnt=%0d word=%h want 2 03", fifoCount, wordOut);
      miscompares++;
    end
    wordReady = 1'b1; idle(1);
    vectors++;
    if (wordOut !== 8'h04 || fifoCount !== 3'd1) begin
      $display("FAIL b2b_head: got %h cnt=%0d want 04 1", wordOut, fifoCount);
      miscompares++;
    end
    idle(1); wordReady = 1'b0;
    vectors++;
    if (wordOut !== 8'h00 || fifoCount !== 3'd0) begin
      $display("FAIL b2b_empty: got %h cnt=%0d want 00 0", wordOut, fifoCount);
      miscompares++;
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h5A, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    rst = 1'b1; bitValid = 1'b1; bitIn = 1'b1; wordReady = 1'b1;
    idle(1);
    rst = 1'b0; bitValid = 1'b0; bitIn = 1'b0; wordReady = 1'b0;
    vectors++;
    if ({wordOut, wordValid, fifoCount, busy, parityErr, timeoutErr, overflowErr} !== 15'd0) begin
      $display("FAIL reset_midframe: got %h wv=%b cnt=%0d busy=%b errs=%b%b%b want all 0",
               wordOut, wordValid, fifoCount, busy, parityErr, timeoutErr, overflowErr);
      miscompares++;
    end
    send_frame(8'hB2, 1'b0);
    vectors++;
    if (wordOut !== 8'hB2 || fifoCount !== 3'd1 || parityErr !== 1'b0) begin
      $display("FAIL post_reset_frame: got %h cnt=%0d perr=%b want b2 1 0", wordOut, fifoCount, parityErr);
      miscompares++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_parity();
    test_timeout();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
